// File: rtl/regfile_onehot_32.sv
// 32-entry register file with a one-hot write port, two combinational read ports,
// a sticky multi-hot write error flag and a wrapping committed-write counter.
module regfile_onehot_32 #(
   parameter int N        = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  wr_ena,
   input  logic [N-1:0] wr_data,
   input  logic [4:0]   rd_addr0,
   input  logic [4:0]   rd_addr1,
   output logic [N-1:0] rd_data0,
   output logic [N-1:0] rd_data1,
   output logic         err_multi,
   output logic [7:0]   wr_count
);

   logic [N-1:0] mem_q [32];
   logic [N-1:0] mem_d [32];
   logic         err_multi_q;
   logic         err_multi_d;
   logic [7:0]   wr_count_q;
   logic [7:0]   wr_count_d;

   logic [4:0]   wr_idx_s;
   logic         wr_any_s;
   logic         wr_multi_s;
   logic         wr_legal_s;
   logic         wr_drop_s;
   logic         wr_commit_s;
   logic         wr_bypass_s;

   // OR-based encoder: exact for one-hot input, no priority chain needed
   always_comb begin
      wr_idx_s = 5'd0;
      for (int i = 0; i < 32; i++) begin
         wr_idx_s = wr_idx_s | ({5{wr_ena[i]}} & 5'(i));
      end
   end

   // Write classification: idle, legal one-hot, or illegal multi-hot
   always_comb begin
      wr_any_s    = (wr_ena != 32'd0);
      wr_multi_s  = ((wr_ena & (wr_ena - 32'd1)) != 32'd0);
      wr_legal_s  = wr_any_s && !wr_multi_s;
      wr_drop_s   = (ZERO_REG != 0) && (wr_idx_s == 5'd0);
      wr_commit_s = wr_legal_s && !wr_drop_s;
      // a write discarded by reset must not be forwarded either
      wr_bypass_s = (BYPASS != 0) && wr_commit_s && !rst;
   end

   // Next-state for the storage array
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         if (wr_commit_s && (wr_idx_s == 5'(i))) begin
            mem_d[i] = wr_data;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Next-state for the error flag and write counter
   always_comb begin
      err_multi_d = err_multi_q | wr_multi_s;
      if (wr_commit_s) begin
         wr_count_d = wr_count_q + 8'd1;
      end else begin
         wr_count_d = wr_count_q;
      end
   end

   // State registers; reset wins over any write in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= {N{1'b0}};
         end
         err_multi_q <= 1'b0;
         wr_count_q  <= 8'd0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= mem_d[i];
         end
         err_multi_q <= err_multi_d;
         wr_count_q  <= wr_count_d;
      end
   end

   // Read port 0
   always_comb begin
      if ((ZERO_REG != 0) && (rd_addr0 == 5'd0)) begin
         rd_data0 = {N{1'b0}};
      end else if (wr_bypass_s && (rd_addr0 == wr_idx_s)) begin
         rd_data0 = wr_data;
      end else begin
         rd_data0 = mem_q[rd_addr0];
      end
   end

   // Read port 1
   always_comb begin
      if ((ZERO_REG != 0) && (rd_addr1 == 5'd0)) begin
         rd_data1 = {N{1'b0}};
      end else if (wr_bypass_s && (rd_addr1 == wr_idx_s)) begin
         rd_data1 = wr_data;
      end else begin
         rd_data1 = mem_q[rd_addr1];
      end
   end

   assign err_multi = err_multi_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_32.sv
// Directed bench for regfile_onehot_32: a vector table plus hand sequences,
// run against three parameterisations sharing one set of inputs.
module tb_regfile_onehot_32;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wr_ena;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr0;
   logic [4:0]  rd_addr1;

   logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, z_rd0, z_rd1;
   logic        a_err, b_err, z_err;
   logic [7:0]  a_cnt, b_cnt, z_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_onehot_32 #(.N(32), .ZERO_REG(1), .BYPASS(0)) dut (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(a_rd0), .rd_data1(a_rd1), .err_multi(a_err), .wr_count(a_cnt));

   regfile_onehot_32 #(.N(32), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(b_rd0), .rd_data1(b_rd1), .err_multi(b_err), .wr_count(b_cnt));

   regfile_onehot_32 #(.N(32), .ZERO_REG(0), .BYPASS(0)) dut_z (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(z_rd0), .rd_data1(z_rd1), .err_multi(z_err), .wr_count(z_cnt));

   typedef struct {
      logic [31:0] ena;
      logic [31:0] data;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] rd0;      // pre-edge, BYPASS=0
      logic [31:0] rd1;
      logic [31:0] brd0;     // pre-edge, BYPASS=1
      logic [31:0] brd1;
      logic        err;      // after the edge
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ena, input logic [31:0] data,
                        input logic [4:0] a0, input logic [4:0] a1);
      wr_ena   = ena;
      wr_data  = data;
      rd_addr0 = a0;
      rd_addr1 = a1;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 5'd3,  5'd3,  32'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 8'd1};
      vecs[1] = '{32'h0000_0000, 32'h0,         5'd3,  5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 8'd1};
      vecs[2] = '{32'h0000_0001, 32'h0000_1234, 5'd0,  5'd3,  32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 8'd1};
      vecs[3] = '{32'h0000_0000, 32'h0,         5'd0,  5'd3,  32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 8'd1};
      vecs[4] = '{32'h0000_0010, 32'h0000_000A, 5'd4,  5'd5,  32'h0, 32'h0, 32'hA, 32'h0, 1'b0, 8'd2};
      vecs[5] = '{32'h0000_0020, 32'h0000_000B, 5'd4,  5'd5,  32'hA, 32'h0, 32'hA, 32'hB, 1'b0, 8'd3};
      vecs[6] = '{32'h0000_0030, 32'hFFFF_FFFF, 5'd4,  5'd5,  32'hA, 32'hB, 32'hA, 32'hB, 1'b1, 8'd3};
      vecs[7] = '{32'h0000_0000, 32'h0,         5'd4,  5'd5,  32'hA, 32'hB, 32'hA, 32'hB, 1'b1, 8'd3};
      vecs[8] = '{32'h8000_0000, 32'h0000_0031, 5'd31, 5'd31, 32'h0, 32'h0, 32'h31, 32'h31, 1'b1, 8'd4};
      vecs[9] = '{32'h0000_0000, 32'h0,         5'd31, 5'd3,  32'h31, 32'hDEAD_BEEF, 32'h31, 32'hDEAD_BEEF, 1'b1, 8'd4};

      // reset then read
      rst = 1'b1;
      drive(32'h0, 32'h0, 5'd5, 5'd31);
      @(posedge clk); #1;
      chk("reset_rd0", a_rd0, 32'h0);
      chk("reset_rd1", a_rd1, 32'h0);
      chk("reset_err", {31'd0, a_err}, 32'h0);
      chk("reset_cnt", {24'd0, a_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // vector table: one cycle each, reads before the edge, state after
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].ena, vecs[v].data, vecs[v].a0, vecs[v].a1);
         #1;
         chk($sformatf("v%0d_rd0", v), a_rd0, vecs[v].rd0);
         chk($sformatf("v%0d_rd1", v), a_rd1, vecs[v].rd1);
         chk($sformatf("v%0d_byp_rd0", v), b_rd0, vecs[v].brd0);
         chk($sformatf("v%0d_byp_rd1", v), b_rd1, vecs[v].brd1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_err", v), {31'd0, a_err}, {31'd0, vecs[v].err});
         chk($sformatf("v%0d_cnt", v), {24'd0, a_cnt}, {24'd0, vecs[v].cnt});
         @(negedge clk);
      end

      // without a zero register, entry 0 is an ordinary, counted entry
      drive(32'h0, 32'h0, 5'd0, 5'd0);
      #1;
      chk("z_entry0", z_rd0, 32'h0000_1234);
      chk("z_cnt", {24'd0, z_cnt}, 32'd5);
      chk("a_entry0", a_rd0, 32'h0);

      // sticky error across idle cycles
      repeat (10) @(posedge clk);
      #1;
      chk("err_sticky", {31'd0, a_err}, 32'h1);
      chk("cnt_hold_idle", {24'd0, a_cnt}, 32'd4);
      @(negedge clk);

      // clean reset, then 256 writes wrap the counter
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset2_rd_entry0", a_rd0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h0, 32'h0, 5'd3, 5'd31);
      #1;
      chk("reset2_entry3", a_rd0, 32'h0);
      chk("reset2_entry31", a_rd1, 32'h0);
      chk("reset2_err", {31'd0, a_err}, 32'h0);
      for (int i = 0; i < 256; i++) begin
         logic [31:0] one;
         one = 32'd1;
         drive(one << ((i % 31) + 1), 32'(i), 5'd8, 5'd1);
         @(posedge clk); #1;
         chk($sformatf("wrap_cnt_%0d", i), {24'd0, a_cnt}, 32'((i + 1) % 256));
         @(negedge clk);
      end
      drive(32'h0, 32'h0, 5'd8, 5'd1);
      #1;
      chk("wrap_entry8", a_rd0, 32'd255);
      chk("wrap_entry1", a_rd1, 32'd248);
      drive(32'h0000_0004, 32'h77, 5'd2, 5'd2);
      @(posedge clk); #1;
      chk("wrap_257", {24'd0, a_cnt}, 32'd1);
      @(negedge clk);

      // reset mid-stream discards the concurrent write and clears the flag
      drive(32'h0000_0080, 32'h55, 5'd7, 5'd7);
      @(posedge clk); #1;
      chk("mid_cnt", {24'd0, a_cnt}, 32'd2);
      @(negedge clk);
      drive(32'h0000_0003, 32'h99, 5'd7, 5'd1);
      @(posedge clk); #1;
      chk("mid_err_set", {31'd0, a_err}, 32'h1);
      chk("mid_entry7", a_rd0, 32'h55);
      @(negedge clk);
      rst = 1'b1;
      drive(32'h0000_0080, 32'h66, 5'd7, 5'd7);
      #1;
      chk("rst_pre_edge_rd", a_rd0, 32'h55);
      chk("rst_no_bypass", b_rd0, 32'h55);
      @(posedge clk); #1;
      chk("rst_entry7", a_rd0, 32'h0);
      chk("rst_err", {31'd0, a_err}, 32'h0);
      chk("rst_cnt", {24'd0, a_cnt}, 32'h0);
      chk("rst_byp_cnt", {24'd0, b_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h0, 32'h0, 5'd7, 5'd7);
      #1;
      chk("after_rst_entry7", a_rd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
